// File: rtl/lfsr_offset_search.sv
// lfsr_offset_search: drives an external free-running lfsr stage and measures
// how many shifts separate a known seed from a captured target word.
// The lfsr has no reset of its own, so this block sequences its enable:
// a short flush after reset, a two-cycle arm while the lfsr loads the seed,
// a search that compares every produced word, and a two-cycle drain.
`timescale 1ns/1ps
module lfsr_offset_search #(
  parameter int WIDTH = 17
) (
  input  logic             clk_72MHz,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] polynomial_in,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [WIDTH-1:0] target_in,
  input  logic [WIDTH-1:0] max_iterations,
  output logic [WIDTH-1:0] lfsr_polynomial,
  output logic [WIDTH-1:0] lfsr_start_data,
  output logic             lfsr_enable,
  input  logic [WIDTH-1:0] lfsr_value,
  input  logic [WIDTH-1:0] lfsr_iteration_number,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] offset
);

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_ARM,
    ST_SEARCH,
    ST_DRAIN
  } state_t;

  state_t           state_q;
  logic             cnt_q;          // second-cycle flag for FLUSH / ARM / DRAIN
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] poly_q;
  logic [WIDTH-1:0] seed_q;
  logic             enable_q;
  logic             busy_q;
  logic             done_q;
  logic             found_q;
  logic [WIDTH-1:0] offset_q;

  // Compare results for the current lfsr word; a match takes priority over the limit.
  logic match_d;
  logic limit_d;

  assign match_d = (lfsr_value == target_q);
  assign limit_d = (lfsr_iteration_number == max_q);

  // Search sequencer: all outputs are registered here.
  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      state_q  <= ST_FLUSH;
      cnt_q    <= 1'b0;
      target_q <= '0;
      max_q    <= '0;
      poly_q   <= '0;
      seed_q   <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      offset_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_FLUSH: begin
          // Enable held low so the lfsr falls back to its idle state.
          enable_q <= 1'b0;
          if (cnt_q) begin
            cnt_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (start) begin
            poly_q   <= polynomial_in;
            seed_q   <= seed_in;
            target_q <= target_in;
            max_q    <= max_iterations;
            enable_q <= 1'b1;
            busy_q   <= 1'b1;
            found_q  <= 1'b0;
            cnt_q    <= 1'b0;
            state_q  <= ST_ARM;
          end
        end
        ST_ARM: begin
          // lfsr goes IDLE->LOAD->ITERATE; its outputs are not valid yet.
          if (cnt_q) begin
            cnt_q   <= 1'b0;
            state_q <= ST_SEARCH;
          end else begin
            cnt_q <= 1'b1;
          end
        end
        ST_SEARCH: begin
          if (match_d) begin
            found_q  <= 1'b1;
            offset_q <= lfsr_iteration_number;
            enable_q <= 1'b0;
            state_q  <= ST_DRAIN;
          end else if (limit_d) begin
            found_q  <= 1'b0;
            offset_q <= max_q;
            enable_q <= 1'b0;
            state_q  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Let the lfsr observe the low enable and return to idle before reporting.
          if (cnt_q) begin
            cnt_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= 1'b1;
          end
        end
        default: begin
          cnt_q    <= 1'b0;
          enable_q <= 1'b0;
          busy_q   <= 1'b1;
          state_q  <= ST_FLUSH;
        end
      endcase
    end
  end

  assign lfsr_polynomial = poly_q;
  assign lfsr_start_data = seed_q;
  assign lfsr_enable     = enable_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign found           = found_q;
  assign offset          = offset_q;

endmodule

// File: tb/tb_lfsr_offset_search.sv
// Bench for lfsr_offset_search: models the external lfsr stage, runs directed
// and random searches, and checks results and timing against a reference that
// simply walks the shift sequence from the seed.
`timescale 1ns/1ps
module tb_lfsr_offset_search;

  localparam int W = 17;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] polynomial_in, seed_in, target_in, max_iterations;
  logic [W-1:0] lfsr_polynomial, lfsr_start_data;
  logic         lfsr_enable;
  logic [W-1:0] lfsr_value, lfsr_iteration_number;
  logic         busy, done, found;
  logic [W-1:0] offset;

  int total = 0;
  int bad   = 0;

  always #7 clk = ~clk;

  lfsr_offset_search #(.WIDTH(W)) dut (
    .clk_72MHz             (clk),
    .reset                 (reset),
    .start                 (start),
    .polynomial_in         (polynomial_in),
    .seed_in               (seed_in),
    .target_in             (target_in),
    .max_iterations        (max_iterations),
    .lfsr_polynomial       (lfsr_polynomial),
    .lfsr_start_data       (lfsr_start_data),
    .lfsr_enable           (lfsr_enable),
    .lfsr_value            (lfsr_value),
    .lfsr_iteration_number (lfsr_iteration_number),
    .busy                  (busy),
    .done                  (done),
    .found                 (found),
    .offset                (offset)
  );

  // One shift of a right-shifting Galois lfsr.
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] poly, input logic [W-1:0] v);
    return v[0] ? ((v >> 1) ^ poly) : (v >> 1);
  endfunction

  function automatic logic [W-1:0] advance(input logic [W-1:0] poly, input logic [W-1:0] v, input int k);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = lfsr_step(poly, r);
    return r;
  endfunction

  // Reference: first iteration index in [0, max] whose word equals the target.
  task automatic ref_search(input logic [W-1:0] poly, input logic [W-1:0] seed,
                            input logic [W-1:0] target, input logic [W-1:0] maxi,
                            output logic f, output logic [W-1:0] off);
    logic [W-1:0] v;
    v   = seed;
    f   = 1'b0;
    off = maxi;
    for (int k = 0; k <= int'(maxi); k++) begin
      if (v == target) begin
        f   = 1'b1;
        off = W'(k);
        break;
      end
      v = lfsr_step(poly, v);
    end
  endtask

  // Environment model of the lfsr stage (no reset): IDLE -> LOAD -> ITERATE.
  int           m_state = 0;
  logic [W-1:0] m_val   = '0;
  logic [W-1:0] m_iter  = '0;

  always @(posedge clk) begin
    case (m_state)
      0: if (lfsr_enable === 1'b1) m_state <= 1;
      1: begin
        m_val   <= lfsr_start_data;
        m_iter  <= '0;
        m_state <= (lfsr_enable === 1'b1) ? 2 : 0;
      end
      default: begin
        if (lfsr_enable === 1'b1) begin
          m_val  <= lfsr_step(lfsr_polynomial, m_val);
          m_iter <= m_iter + 1'b1;
        end else begin
          m_state <= 0;
        end
      end
    endcase
  end

  assign lfsr_value            = m_val;
  assign lfsr_iteration_number = m_iter;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts at a negedge (may be the done cycle of a previous search) and
  // returns at the negedge where done is seen.
  task automatic do_search(input string tag, input logic [W-1:0] poly, input logic [W-1:0] seed,
                           input logic [W-1:0] target, input logic [W-1:0] maxi, input int pulse_at);
    logic         exp_f;
    logic [W-1:0] exp_off;
    int           exp_lat, n, en_low;
    logic         seen;
    ref_search(poly, seed, target, maxi, exp_f, exp_off);
    exp_lat = int'(exp_off) + 5;
    polynomial_in  = poly;
    seed_in        = seed;
    target_in      = target;
    max_iterations = maxi;
    start          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_en_rise"}, 32'(lfsr_enable), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_found_clr"}, 32'(found), 32'd0);
    check({tag, "_poly_out"}, 32'(lfsr_polynomial), 32'(poly));
    check({tag, "_seed_out"}, 32'(lfsr_start_data), 32'(seed));
    en_low = -1;
    seen   = 1'b0;
    for (n = 1; n <= int'(maxi) + 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      start = (n == pulse_at);
      if (!lfsr_enable && en_low < 0) en_low = n;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_en_low_at"}, 32'(en_low), 32'(exp_lat - 2));
    check({tag, "_found"}, 32'(found), 32'(exp_f));
    check({tag, "_offset"}, 32'(offset), 32'(exp_off));
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    $display("search %s: seed=%0h target=%0h max=%0d -> found=%0d offset=%0d latency=%0d",
             tag, seed, target, maxi, found, offset, n);
  endtask

  localparam logic [W-1:0] POLY = 17'h1D258;

  initial begin
    logic [W-1:0] s, p, mx;
    int           k, waitn;
    reset = 1'b1;
    start = 1'b0;
    polynomial_in  = '0;
    seed_in        = '0;
    target_in      = '0;
    max_iterations = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_en", 32'(lfsr_enable), 32'd0);
    check("rst_offset", 32'(offset), 32'd0);
    check("rst_poly", 32'(lfsr_polynomial), 32'd0);
    check("rst_seed", 32'(lfsr_start_data), 32'd0);

    // Flush: busy for two cycles after release, then idle, no done.
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("flush1_busy", 32'(busy), 32'd1);
    check("flush1_en", 32'(lfsr_enable), 32'd0);
    check("flush1_done", 32'(done), 32'd0);
    @(posedge clk); @(negedge clk);
    check("flush2_busy", 32'(busy), 32'd0);
    check("flush2_en", 32'(lfsr_enable), 32'd0);
    check("flush2_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_en", 32'(lfsr_enable), 32'd0);
    $display("reset/flush sequence checked");

    // Directed searches.
    do_search("match0", POLY, 17'h00001, 17'h00001, 17'd100, -1);
    @(posedge clk); @(negedge clk);
    do_search("k37", POLY, 17'h00001, advance(POLY, 17'h00001, 37), 17'd100, -1);
    @(posedge clk); @(negedge clk);
    do_search("unreach", POLY, 17'h00001, 17'h00000, 17'd100, -1);
    @(posedge clk); @(negedge clk);
    do_search("max0", POLY, 17'h00005, 17'h00009, 17'd0, -1);
    @(posedge clk); @(negedge clk);
    do_search("tie12", POLY, 17'h0ABCD, advance(POLY, 17'h0ABCD, 12), 17'd12, -1);
    @(posedge clk); @(negedge clk);

    // start during SEARCH is ignored; start in the done cycle is accepted.
    do_search("pulse", POLY, 17'h00001, advance(POLY, 17'h00001, 30), 17'd100, 10);
    do_search("chain", POLY, 17'h00003, advance(POLY, 17'h00003, 3), 17'd50, -1);
    @(posedge clk); @(negedge clk);
    check("no_queue_busy", 32'(busy), 32'd0);
    check("no_queue_en", 32'(lfsr_enable), 32'd0);

    // Random searches.
    for (int r = 0; r < 8; r++) begin
      s  = W'($urandom_range(1, 17'h1FFFF));
      p  = (r % 2 == 0) ? POLY : (W'($urandom) | 17'h10000);
      k  = $urandom_range(0, 40);
      mx = W'($urandom_range(0, 50));
      do_search($sformatf("rnd%0d", r), p, s, advance(p, s, k), mx, -1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(negedge clk);
    end

    // Reset mid-SEARCH at iteration 20.
    polynomial_in  = POLY;
    seed_in        = 17'h00001;
    target_in      = 17'h00000;
    max_iterations = 17'd100;
    start          = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    waitn = 0;
    while (lfsr_iteration_number !== 17'd20 && waitn < 40) begin
      @(posedge clk); @(negedge clk);
      waitn++;
    end
    check("midrst_reach20", 32'(lfsr_iteration_number), 32'd20);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_en", 32'(lfsr_enable), 32'd0);
    check("midrst_found", 32'(found), 32'd0);
    check("midrst_offset", 32'(offset), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midrst_flush1", 32'(busy), 32'd1);
    @(posedge clk); @(negedge clk);
    check("midrst_flush2", 32'(busy), 32'd0);
    check("midrst_nodone", 32'(done), 32'd0);
    $display("mid-search reset checked");
    do_search("after_rst", POLY, 17'h00001, advance(POLY, 17'h00001, 5), 17'd100, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
